// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - master-side bus interface: CPU strobe to request/grant/strobe/ready bus cycle
//
// Purpose:
//   Turns a one-cycle CPU access strobe into a bus cycle. The cycle raises an
//   active-low request, waits for an active-low grant, drives address, strobe
//   and data, then waits for an active-low slave ready. Read data and
//   completion/error status go back to the CPU as one-cycle pulses.
//   A slave-response timeout and grant-loss detection abort stuck cycles.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-low reset
//   cpu_as_           CPU access strobe, active-low, sampled only when idle
//   cpu_rw            1 = read, 0 = write
//   cpu_addr          word address
//   cpu_wr_data       write data
//   cpu_rd_data       read data, valid while cpu_rdy_ is low
//   cpu_rdy_          one-cycle completion pulse, active-low
//   cpu_err_          one-cycle error pulse, active-low, coincident with cpu_rdy_
//   cpu_busy          high whenever a cycle is in progress
//   bus_req_          request to arbiter, active-low
//   bus_grnt_         grant from arbiter, active-low
//   bus_addr          bus address, 0 when not accessing
//   bus_as_           bus address strobe, active-low
//   bus_rw            bus direction, 1 when not accessing
//   bus_wr_data       bus write data, 0 when not accessing
//   bus_rd_data       read data from slave mux
//   bus_rdy_          slave ready, active-low

module bus_master_if #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_as_,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wr_data,
  output logic [DW-1:0] cpu_rd_data,
  output logic          cpu_rdy_,
  output logic          cpu_err_,
  output logic          cpu_busy,
  output logic          bus_req_,
  input  logic          bus_grnt_,
  output logic [AW-1:0] bus_addr,
  output logic          bus_as_,
  output logic          bus_rw,
  output logic [DW-1:0] bus_wr_data,
  input  logic [DW-1:0] bus_rd_data,
  input  logic          bus_rdy_
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam bit       TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rd_data_q, cpu_rd_data_d;
  logic          cpu_rdy_q, cpu_rdy_d;
  logic          cpu_err_q, cpu_err_d;
  logic          cpu_busy_q, cpu_busy_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_as_q, bus_as_d;
  logic          bus_rw_q, bus_rw_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wr_data_q, bus_wr_data_d;

  // Ends the current cycle: either normal completion or abort.
  logic          finish;
  logic          finish_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rw_q          <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      cpu_rd_data_q <= '0;
      cpu_rdy_q     <= 1'b1;
      cpu_err_q     <= 1'b1;
      cpu_busy_q    <= 1'b0;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cpu_rd_data_q <= cpu_rd_data_d;
      cpu_rdy_q     <= cpu_rdy_d;
      cpu_err_q     <= cpu_err_d;
      cpu_busy_q    <= cpu_busy_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cpu_rd_data_d = cpu_rd_data_q;
    cpu_rdy_d     = 1'b1;
    cpu_err_d     = 1'b1;
    cpu_busy_d    = cpu_busy_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    finish        = 1'b0;
    finish_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!cpu_as_) begin
          rw_d       = cpu_rw;
          addr_d     = cpu_addr;
          wdata_d    = cpu_wr_data;
          state_d    = S_REQ;
          bus_req_d  = 1'b0;
          cpu_busy_d = 1'b1;
        end
      end

      // Grant is only looked at from REQ, so REQ always lasts one cycle even
      // when the grant is already held.
      S_REQ: begin
        if (!bus_grnt_) begin
          state_d       = S_ACCESS;
          bus_as_d      = 1'b0;
          bus_rw_d      = rw_q;
          bus_addr_d    = addr_q;
          bus_wr_data_d = wdata_q;
          cnt_d         = '0;
        end
      end

      S_ACCESS: begin
        if (bus_grnt_) begin
          // Grant lost mid-cycle: abort, regardless of slave ready.
          finish     = 1'b1;
          finish_err = 1'b1;
        end else if (!bus_rdy_) begin
          finish = 1'b1;
          if (rw_q) begin
            cpu_rd_data_d = bus_rd_data;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus outputs return to zero/idle values so several masters can be OR-ed.
    if (finish) begin
      state_d       = S_IDLE;
      cpu_rdy_d     = 1'b0;
      cpu_err_d     = !finish_err;
      cpu_busy_d    = 1'b0;
      bus_req_d     = 1'b1;
      bus_as_d      = 1'b1;
      bus_rw_d      = 1'b1;
      bus_addr_d    = '0;
      bus_wr_data_d = '0;
    end
  end

  assign cpu_rd_data = cpu_rd_data_q;
  assign cpu_rdy_    = cpu_rdy_q;
  assign cpu_err_    = cpu_err_q;
  assign cpu_busy    = cpu_busy_q;
  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - directed self-checking bench for bus_master_if
module tb_bus_master_if;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_as_;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rdy_;
  logic          cpu_err_;
  logic          cpu_busy;
  logic          bus_req_;
  logic          bus_grnt_;
  logic [AW-1:0] bus_addr;
  logic          bus_as_;
  logic          bus_rw;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data;
  logic          bus_rdy_;

  int n_chk  = 0;
  int n_pass = 0;

  bus_master_if #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_as_     (cpu_as_),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_rdy_    (cpu_rdy_),
    .cpu_err_    (cpu_err_),
    .cpu_busy    (cpu_busy),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_addr    (bus_addr),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one CPU access with a scripted arbiter/slave. gnt_delay = cycles the
  // grant stays high after the request; waits = slave wait states;
  // drop_at = ACCESS cycle in which the grant is removed (0 = never).
  task automatic do_access(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int gnt_delay, input int waits, input int drop_at,
                           output int as_cyc, output int edges, output int bad, output logic req1);
    int req_cyc;
    cpu_as_     = 1'b0;
    cpu_rw      = rw;
    cpu_addr    = addr;
    cpu_wr_data = wd;
    bus_rdy_    = 1'b1;
    bus_grnt_   = (gnt_delay == 0) ? 1'b0 : 1'b1;
    as_cyc = 0; edges = 0; bad = 0; req_cyc = 0; req1 = 1'bx;
    do begin
      step();
      edges++;
      cpu_as_ = 1'b1;
      if (edges == 1) req1 = bus_req_;
      if (bus_as_ === 1'b0) begin
        as_cyc++;
        if (bus_addr !== addr || bus_rw !== rw || bus_wr_data !== wd) bad++;
        bus_rdy_ = (as_cyc > waits) ? 1'b0 : 1'b1;
        if (drop_at != 0 && as_cyc == drop_at) bus_grnt_ = 1'b1;
      end else begin
        if (bus_addr !== '0 || bus_rw !== 1'b1 || bus_wr_data !== '0) bad++;
        if (bus_req_ === 1'b0) begin
          req_cyc++;
          bus_grnt_ = (req_cyc > gnt_delay) ? 1'b0 : 1'b1;
        end
      end
    end while (cpu_rdy_ !== 1'b0 && edges < 100);
    bus_rdy_  = 1'b1;
    bus_grnt_ = 1'b0;
  endtask

  int   as_cyc, edges, bad;
  logic req1;

  initial begin
    reset       = 1'b0;
    cpu_as_     = 1'b1;
    cpu_rw      = 1'b1;
    cpu_addr    = '0;
    cpu_wr_data = '0;
    bus_grnt_   = 1'b0;
    bus_rd_data = '0;
    bus_rdy_    = 1'b1;
    step();
    step();
    check("rst_rdy",   cpu_rdy_, 1);
    check("rst_err",   cpu_err_, 1);
    check("rst_busy",  cpu_busy, 0);
    check("rst_req",   bus_req_, 1);
    check("rst_as",    bus_as_, 1);
    check("rst_rw",    bus_rw, 1);
    check("rst_addr",  bus_addr, 0);
    check("rst_wdata", bus_wr_data, 0);
    check("rst_rdata", cpu_rd_data, 0);
    reset = 1'b1;
    step();

    // Read, grant pre-held, zero-wait slave.
    bus_rd_data = 32'hDEADBEEF;
    do_access(1'b1, 30'h100, 32'h0, 0, 0, 0, as_cyc, edges, bad, req1);
    check("rd_edges",  edges, 3);
    check("rd_as_cyc", as_cyc, 1);
    check("rd_bus",    bad, 0);
    check("rd_req1",   req1, 0);
    check("rd_data",   cpu_rd_data, 32'hDEADBEEF);
    check("rd_err",    cpu_err_, 1);
    check("rd_busy",   cpu_busy, 0);
    check("rd_req_rel", bus_req_, 1);
    step();
    check("rd_rdy_pulse", cpu_rdy_, 1);

    // Write with 3 wait states; read data register must not change.
    bus_rd_data = 32'hCAFEF00D;
    do_access(1'b0, 30'h200, 32'h12345678, 0, 3, 0, as_cyc, edges, bad, req1);
    check("wr_edges",  edges, 6);
    check("wr_as_cyc", as_cyc, 4);
    check("wr_bus",    bad, 0);
    check("wr_err",    cpu_err_, 1);
    check("wr_rdata",  cpu_rd_data, 32'hDEADBEEF);
    check("b2b_req_hi", bus_req_, 1);

    // Back-to-back read started in the cpu_rdy_ cycle.
    bus_rd_data = 32'h0BADC0DE;
    do_access(1'b1, 30'h300, 32'h0, 0, 0, 0, as_cyc, edges, bad, req1);
    check("b2b_req_lo", req1, 0);
    check("b2b_edges",  edges, 3);
    check("b2b_data",   cpu_rd_data, 32'h0BADC0DE);
    step();

    // Grant delayed 5 cycles after request.
    bus_rd_data = 32'h55AA_33CC;
    do_access(1'b1, 30'h3FFF_FFFF, 32'h0, 5, 0, 0, as_cyc, edges, bad, req1);
    check("dg_edges", edges, 8);
    check("dg_as",    as_cyc, 1);
    check("dg_bus",   bad, 0);
    check("dg_data",  cpu_rd_data, 32'h55AA_33CC);
    step();

    // Arbiter switching owner: one cycle of grant delay gives 4-edge latency.
    do_access(1'b0, 30'h44, 32'hFFFF_FFFF, 1, 0, 0, as_cyc, edges, bad, req1);
    check("sw_edges", edges, 4);
    check("sw_bus",   bad, 0);
    step();

    // Slave never responds: timeout after 16 strobe cycles.
    do_access(1'b1, 30'h500, 32'h0, 0, 1000, 0, as_cyc, edges, bad, req1);
    check("to_as_cyc", as_cyc, 16);
    check("to_edges",  edges, 18);
    check("to_rdy",    cpu_rdy_, 0);
    check("to_err",    cpu_err_, 0);
    check("to_req",    bus_req_, 1);
    check("to_rdata",  cpu_rd_data, 32'h55AA_33CC);
    step();
    check("to_err_pulse", cpu_err_, 1);

    // Grant lost in the second ACCESS cycle.
    do_access(1'b1, 30'h600, 32'h0, 0, 1000, 2, as_cyc, edges, bad, req1);
    check("gl_as_cyc", as_cyc, 2);
    check("gl_edges",  edges, 4);
    check("gl_err",    cpu_err_, 0);
    check("gl_rdata",  cpu_rd_data, 32'h55AA_33CC);
    step();

    // Reset asserted in the middle of ACCESS.
    cpu_as_ = 1'b0; cpu_rw = 1'b0; cpu_addr = 30'h700; cpu_wr_data = 32'h1;
    step();
    cpu_as_ = 1'b1;
    step();
    check("mr_as_low", bus_as_, 0);
    #2;
    reset = 1'b0;
    #1;
    check("mr_as",   bus_as_, 1);
    check("mr_req",  bus_req_, 1);
    check("mr_busy", cpu_busy, 0);
    check("mr_addr", bus_addr, 0);
    step();
    check("mr_rdy",  cpu_rdy_, 1);
    reset = 1'b1;
    step();
    check("mr_rdy2", cpu_rdy_, 1);
    check("mr_idle", cpu_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
